banco_registros: RTL and testbench

//  Register bank for the single-cycle datapath, 2^AW x DW. Feeds the ALU/Add_1 operand mux path.

---
 rtl/datapath_pkg.sv | 13 +
 rtl/banco_registros_dump_seq.sv | 66 ++++++
 rtl/banco_registros.sv | 76 +++++++
 tb/tb_banco_registros.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-cycle datapath: default widths and the
// register-bank dump sequencer state encoding.
package datapath_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

endpackage

// File: rtl/banco_registros_dump_seq.sv
// Dump sequencer for banco_registros: walks every register index once per
// dump_start and presents each value on a valid/ready stream.
module banco_dump_seq
  import datapath_pkg::*;
#(
  parameter int unsigned DW = datapath_pkg::DW,
  parameter int unsigned AW = datapath_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_busy
);

  dump_state_t state;
  logic        last;

  assign last = (dump_addr == '1);

  // The bank answers rd_addr with write-through, so capturing rd_data on the
  // loading edge yields the post-write contents of the next index.
  assign rd_addr = (state == IDLE) ? '0 : dump_addr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SEND;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_addr  <= '0;
            dump_data  <= rd_data;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (last) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              dump_busy  <= 1'b0;
              dump_addr  <= '0;
            end else begin
              dump_addr <= rd_addr;
              dump_data <= rd_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/banco_registros.sv
// Register bank for the single-cycle datapath: two combinational read ports
// with write-through bypass, one write port, and a serial debug dump stream.
module banco_registros
  import datapath_pkg::*;
#(
  parameter int unsigned DW  = datapath_pkg::DW,
  parameter int unsigned AW  = datapath_pkg::AW,
  parameter bit          R0Z = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          dump_start,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] regs [DEPTH];
  logic          wr_ok;
  logic [AW-1:0] seq_addr;
  logic [DW-1:0] seq_data;

  assign wr_ok = we && !(R0Z && (wa == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [DW-1:0] port_read(
    input logic [AW-1:0] a,
    input logic [DW-1:0] stored,
    input logic          wen,
    input logic [AW-1:0] waddr,
    input logic [DW-1:0] wdata
  );
    if (R0Z && (a == '0)) return '0;
    if (wen && (waddr == a)) return wdata;
    return stored;
  endfunction

  assign rd1      = rst ? '0 : port_read(ra1, regs[ra1], wr_ok, wa, wd);
  assign rd2      = rst ? '0 : port_read(ra2, regs[ra2], wr_ok, wa, wd);
  assign seq_data = port_read(seq_addr, regs[seq_addr], wr_ok, wa, wd);

  banco_dump_seq #(
    .DW(DW),
    .AW(AW)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .rd_addr   (seq_addr),
    .rd_data   (seq_data),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_busy (dump_busy)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: directed scenarios plus a random
// phase, compared every cycle against an array-based model of the bank.
`timescale 1ns/1ps
module tb_banco_registros;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;

  logic [31:0] rd1, rd2, dd;
  logic        dv, db;
  logic [3:0]  da;
  logic [31:0] rd1_0, rd2_0, dd0;
  logic        dv0, db0;
  logic [3:0]  da0;

  int unsigned n_chk = 0, n_fail = 0;
  bit          chk_en = 1'b0;

  always #10 clk = ~clk;

  banco_registros #(.DW(32), .AW(4), .R0Z(1'b1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .dump_start(dump_start), .dump_valid(dv),
    .dump_ready(dump_ready), .dump_addr(da), .dump_data(dd), .dump_busy(db)
  );

  banco_registros #(.DW(32), .AW(4), .R0Z(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
    .we(we), .wa(wa), .wd(wd), .dump_start(1'b0), .dump_valid(dv0),
    .dump_ready(1'b1), .dump_addr(da0), .dump_data(dd0), .dump_busy(db0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m1 [16];
  logic [31:0] m0 [16];
  bit          mvalid;
  int unsigned midx;
  logic [31:0] mdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin m1[i] = '0; m0[i] = '0; end
      mvalid = 1'b0; midx = 0; mdata = '0;
    end else begin
      if (we) begin
        m0[wa] = wd;
        if (wa != 4'd0) m1[wa] = wd;
      end
      if (!mvalid) begin
        if (dump_start) begin mvalid = 1'b1; midx = 0; mdata = m1[0]; end
      end else if (dump_ready) begin
        if (midx == 15) begin mvalid = 1'b0; midx = 0; end
        else begin midx = midx + 1; mdata = m1[midx]; end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit r0z, input logic [3:0] a, input logic [31:0] stored);
    if (rst) return '0;
    if (r0z && a == 4'd0) return '0;
    if (we && wa == a && !(r0z && wa == 4'd0)) return wd;
    return stored;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1", rd1, exp_rd(1'b1, ra1, m1[ra1]));
      check("rd2", rd2, exp_rd(1'b1, ra2, m1[ra2]));
      check("rd1_r0z0", rd1_0, exp_rd(1'b0, ra1, m0[ra1]));
      check("rd2_r0z0", rd2_0, exp_rd(1'b0, ra2, m0[ra2]));
      check("dump_valid", {31'b0, dv}, {31'b0, mvalid});
      check("dump_busy", {31'b0, db}, {31'b0, mvalid});
      check("dump_addr", {28'b0, da}, midx);
      if (mvalid) check("dump_data", dd, mdata);
      check("idle_valid_r0z0", {31'b0, dv0}, 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] hdata;
  logic [3:0]  haddr;
  bit          hold, tog, found;
  int          beat;

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // 1. reset between edges clears reads immediately and the whole bank
    we = 1'b1; wa = 4'd5; wd = 32'h0BADF00D; cyc();
    wa = 4'd9; wd = 32'h11112222; ra1 = 4'd5; ra2 = 4'd9;
    rst = 1'b1; #1;
    check("t1_rd1_in_reset", rd1, 32'd0);
    check("t1_rd2_in_reset", rd2, 32'd0);
    #1 rst = 1'b0; we = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) begin
      ra1 = i[3:0]; ra2 = i[3:0]; #1;
      check("t1_rd1_cleared", rd1, 32'd0);
      check("t1_rd0_cleared", rd1_0, 32'd0);
      cyc();
    end

    // 2. write then read, plus same-cycle bypass
    we = 1'b1; wa = 4'd5; wd = 32'hDEADBEEF; ra2 = 4'd5; ra1 = 4'd0; #1;
    check("t2_bypass", rd2, 32'hDEADBEEF);
    cyc(); we = 1'b0; ra1 = 4'd5; #1;
    check("t2_read", rd1, 32'hDEADBEEF);
    cyc();

    // 3. register 0 behaviour for both settings
    we = 1'b1; wa = 4'd0; wd = 32'h1234; ra1 = 4'd0; #1;
    check("t3_r0z1_bypass", rd1, 32'd0);
    check("t3_r0z0_bypass", rd1_0, 32'h1234);
    cyc(); we = 1'b0; #1;
    check("t3_r0z1_later", rd1, 32'd0);
    check("t3_r0z0_later", rd1_0, 32'h1234);
    cyc();

    // 4. dump with ready toggling 1,0,1,0
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = i[3:0]; wd = i * 3; cyc();
    end
    we = 1'b0;
    dump_start = 1'b1; cyc(); dump_start = 1'b0;
    beat = 0; hold = 1'b0; tog = 1'b1;
    for (int c = 0; c < 80 && beat < 16; c++) begin
      dump_ready = tog; tog = !tog; #1;
      check("t4_valid", {31'b0, dv}, 32'd1);
      if (hold) begin
        check("t4_hold_addr", {28'b0, da}, {28'b0, haddr});
        check("t4_hold_data", dd, hdata);
        hold = 1'b0;
      end
      if (dump_ready) begin
        check("t4_addr", {28'b0, da}, beat);
        check("t4_data", dd, beat * 3);
        beat++;
      end else begin
        haddr = da; hdata = dd; hold = 1'b1;
      end
      cyc();
    end
    check("t4_beats", beat, 16);
    #1;
    check("t4_busy_after", {31'b0, db}, 32'd0);
    check("t4_valid_after", {31'b0, dv}, 32'd0);
    cyc();

    // 5. write to the next index on the advancing edge, then to the held index
    dump_ready = 1'b1; dump_start = 1'b1; cyc(); dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (da == 4'd3) begin
        found = 1'b1;
        we = 1'b1; wa = 4'd4; wd = 32'hA5A5A5A5;
        cyc(); we = 1'b0; dump_ready = 1'b0; #1;
        check("t5_addr4", {28'b0, da}, 32'd4);
        check("t5_new_data", dd, 32'hA5A5A5A5);
        we = 1'b1; wa = 4'd4; wd = 32'h12345678;
        cyc(); we = 1'b0; #1;
        check("t5_held_data", dd, 32'hA5A5A5A5);
        dump_ready = 1'b1;
      end
      cyc();
    end
    check("t5_reached_beat3", {31'b0, found}, 32'd1);
    for (int c = 0; c < 40 && db; c++) cyc();
    check("t5_drained", {31'b0, db}, 32'd0);
    cyc();

    // 6. reset mid-dump, then a fresh dump of the cleared bank
    dump_ready = 1'b1; dump_start = 1'b1; cyc(); dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (da == 4'd7) begin
        found = 1'b1;
        rst = 1'b1; #1;
        check("t6_valid_rst", {31'b0, dv}, 32'd0);
        check("t6_busy_rst", {31'b0, db}, 32'd0);
        check("t6_addr_rst", {28'b0, da}, 32'd0);
        check("t6_data_rst", dd, 32'd0);
        #1 rst = 1'b0;
      end
      cyc();
    end
    check("t6_reached_beat7", {31'b0, found}, 32'd1);
    cyc();
    check("t6_no_beats", {31'b0, dv}, 32'd0);
    dump_start = 1'b1; cyc(); dump_start = 1'b0;
    beat = 0;
    for (int c = 0; c < 40 && beat < 16; c++) begin
      #1;
      check("t6_addr", {28'b0, da}, beat);
      check("t6_data", dd, 32'd0);
      beat++;
      cyc();
    end
    check("t6_beats", beat, 16);
    cyc();

    // random phase
    for (int c = 0; c < 3000; c++) begin
      we         = 1'($urandom_range(0, 1));
      wa         = 4'($urandom_range(0, 15));
      wd         = $urandom;
      ra1        = 4'($urandom_range(0, 15));
      ra2        = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      dump_start = ($urandom_range(0, 15) == 0);
      dump_ready = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 499) == 0);
      if (rst) begin #1 rst = 1'b0; end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
